j_add_arb: RTL and testbench

//  Sequencer/arbiter sharing one external 32-bit fast adder (fa32-class, s/co32) between NREQ

---
 rtl/j_add_arb.sv | 172 +++++++++++++++++
 tb/tb_j_add_arb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/j_add_arb.sv
// j_add_arb: round-robin arbiter and sequencer that shares one external 32-bit
// fast adder between NREQ requesters. A 32-bit add takes one adder pass (LO).
// A 64-bit add takes two passes (LO then HI), and the LO carry-out is chained
// into the HI carry-in. The result is registered, and a one-cycle ack pulse
// goes to the granted requester.
//
// Optional feature: define J_ADDARB_SUB_EN to add the sub port (A-B).
//
// Ports
//   sys_clk    system clock, rising edge
//   xresetl    asynchronous active-low reset
//   req        per-requester request, held until ack
//   dbl        per-requester 64-bit select (two passes)
//   ci         per-requester carry-in for the low pass
//   opa, opb   operands, requester i at [64i+63:64i]
//   sub        (J_ADDARB_SUB_EN only) per-requester subtract select
//   add_a/b    operand words driven to the external adder
//   add_ci     carry-in driven to the external adder
//   add_s      adder sum (combinational)
//   add_co32   adder carry-out
//   ack        one-cycle completion pulse, one-hot
//   res        64-bit result, upper word zero for 32-bit ops
//   co         final carry-out
//   busy       high whenever the sequencer is not idle
module j_add_arb #(
  parameter int NREQ = 2
) (
  input  logic              sys_clk,
  input  logic              xresetl,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dbl,
  input  logic [NREQ-1:0]   ci,
  input  logic [NREQ*64-1:0] opa,
  input  logic [NREQ*64-1:0] opb,
`ifdef J_ADDARB_SUB_EN
  input  logic [NREQ-1:0]   sub,
`endif
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  output logic              add_ci,
  input  logic [31:0]       add_s,
  input  logic              add_co32,
  output logic [NREQ-1:0]   ack,
  output logic [63:0]       res,
  output logic              co,
  output logic              busy
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gidx_q, ptr_q;
  logic            cry_q;
  logic [NREQ-1:0] ack_q;
  logic [63:0]     res_q;
  logic            co_q;

  logic [NREQ-1:0] eligible;
  logic            grantValid;
  logic [IW-1:0]   grantIdx, cand, nextPtr;
  logic            subSel;
  logic [31:0]     wordA, wordB;

  // A requester still holding req during its own ack cycle must not be re-granted.
  assign eligible = req & ~ack_q;

  assign nextPtr = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;

`ifdef J_ADDARB_SUB_EN
  assign subSel = sub[gidx_q];
`else
  assign subSel = 1'b0;
`endif

  // Search for the first eligible requester, starting at ptr and wrapping.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NREQ);
      if (!grantValid && eligible[cand]) begin
        grantValid = 1'b1;
        grantIdx   = cand;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge xresetl) begin
    if (!xresetl) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grantValid) state_d = LO;
      LO:      state_d = dbl[gidx_q] ? HI : IDLE;
      HI:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand words come straight from the granted requester. They must stay stable until ack.
  always_comb begin
    wordA  = '0;
    wordB  = '0;
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    case (state_q)
      LO: begin
        wordA  = opa[int'(gidx_q)*64 +: 32];
        wordB  = opb[int'(gidx_q)*64 +: 32];
        add_a  = wordA;
        add_b  = subSel ? ~wordB : wordB;
        add_ci = subSel ? 1'b1 : ci[gidx_q];
      end
      HI: begin
        wordA  = opa[int'(gidx_q)*64 + 32 +: 32];
        wordB  = opb[int'(gidx_q)*64 + 32 +: 32];
        add_a  = wordA;
        add_b  = subSel ? ~wordB : wordB;
        add_ci = cry_q;
      end
      default: ;
    endcase
  end

  // Datapath registers. ack defaults low every cycle so that it is a single-cycle pulse.
  always_ff @(posedge sys_clk or negedge xresetl) begin
    if (!xresetl) begin
      gidx_q <= '0;
      ptr_q  <= '0;
      cry_q  <= 1'b0;
      ack_q  <= '0;
      res_q  <= '0;
      co_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: if (grantValid) gidx_q <= grantIdx;
        LO: begin
          res_q[31:0] <= add_s;
          if (dbl[gidx_q]) begin
            cry_q <= add_co32;
          end else begin
            res_q[63:32]  <= '0;
            co_q          <= add_co32;
            ack_q[gidx_q] <= 1'b1;
            ptr_q         <= nextPtr;
          end
        end
        HI: begin
          res_q[63:32]  <= add_s;
          co_q          <= add_co32;
          ack_q[gidx_q] <= 1'b1;
          ptr_q         <= nextPtr;
        end
        default: ;
      endcase
    end
  end

  assign ack  = ack_q;
  assign res  = res_q;
  assign co   = co_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_j_add_arb.sv
module tb_j_add_arb;

  localparam int OPS = 40;

  logic         sys_clk;
  logic         xresetl;
  logic         reqA[2];
  logic         dblA[2];
  logic         ciA[2];
  logic [63:0]  aOp[2];
  logic [63:0]  bOp[2];
  logic [1:0]   req, dbl, ci;
  logic [127:0] opa, opb;
`ifdef J_ADDARB_SUB_EN
  logic [1:0]   sub;
`endif
  logic [31:0]  add_a, add_b, add_s;
  logic         add_ci, add_co32;
  logic [1:0]   ack;
  logic [63:0]  res;
  logic         co, busy;
  logic [32:0]  addSum;

  int testCount = 0;
  int failCount = 0;
  bit monActive = 0;
  int pendCnt = 0;
  logic [1:0] expAck = '0;

  assign req = {reqA[1], reqA[0]};
  assign dbl = {dblA[1], dblA[0]};
  assign ci  = {ciA[1], ciA[0]};
  assign opa = {aOp[1], aOp[0]};
  assign opb = {bOp[1], bOp[0]};
`ifdef J_ADDARB_SUB_EN
  assign sub = 2'b00;
`endif

  // Behavioural model of the external fast adder.
  assign addSum   = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_ci};
  assign add_s    = addSum[31:0];
  assign add_co32 = addSum[32];

  j_add_arb #(.NREQ(2)) dut (
    .sys_clk(sys_clk), .xresetl(xresetl), .req(req), .dbl(dbl), .ci(ci),
    .opa(opa), .opb(opb),
`ifdef J_ADDARB_SUB_EN
    .sub(sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s),
    .add_co32(add_co32), .ack(ack), .res(res), .co(co), .busy(busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input int id, input logic [63:0] a, input logic [63:0] b,
                               input logic c, input logic d, input logic r);
    aOp[id]  = a;
    bOp[id]  = b;
    ciA[id]  = c;
    dblA[id] = d;
    reqA[id] = r;
  endtask

  // Reference arithmetic: a 32-bit op adds the low words, and a 64-bit op adds the full words.
  task automatic expectedResult(input logic [63:0] a, input logic [63:0] b, input logic c,
                                input logic d, output logic [63:0] r, output logic k);
    logic [64:0] full;
    logic [32:0] low;
    full = {1'b0, a} + {1'b0, b} + {64'b0, c};
    low  = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'b0, c};
    if (d) begin
      r = full[63:0];
      k = full[64];
    end else begin
      r = {32'b0, low[31:0]};
      k = low[32];
    end
  endtask

  // Random requester: makes a request, waits (bounded) for its ack, and checks the result.
  task automatic agent(input int id);
    logic [63:0] a, b, er;
    logic        c, d, ek;
    int          waited;
    for (int n = 0; n < OPS; n++) begin
      repeat ($urandom_range(0, 3)) waitCycle();
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (n % 4 == 1) begin
        a[31:0] = 32'hFFFF_FFFF;
        b[31:0] = 32'h0000_0001;
      end
      if (n % 5 == 2) a[63:32] = 32'hFFFF_FFFF;
      c = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      applyStimulus(id, a, b, c, d, 1'b1);
      waited = 0;
      do begin
        waitCycle();
        waited++;
      end while (!ack[id] && waited < 20);
      checkOutput("agent_ack_seen", 64'(ack[id]), 64'd1);
      if (ack[id]) begin
        expectedResult(a, b, c, d, er, ek);
        checkOutput("agent_res", res, er);
        checkOutput("agent_co", 64'(co), 64'(ek));
      end
      reqA[id] = 1'b0;
    end
  endtask

  // Fairness monitor: if the other requester is pending in an ack cycle, its ack must come
  // back-to-back (2 cycles for 32-bit, 3 for 64-bit) with no ack in between.
  always @(negedge sys_clk) begin
    if (monActive) begin
      if (pendCnt > 0) begin
        pendCnt--;
        if (pendCnt == 0) checkOutput("rr_next_ack", 64'(ack), 64'(expAck));
        else              checkOutput("rr_gap_ack", 64'(ack), 64'd0);
      end
      if (ack != 2'b00) begin
        checkOutput("ack_onehot", 64'($countones(ack)), 64'd1);
        if (pendCnt == 0) begin
          if (ack[0] && reqA[1]) begin
            pendCnt = dblA[1] ? 3 : 2;
            expAck  = 2'b10;
          end else if (ack[1] && reqA[0]) begin
            pendCnt = dblA[0] ? 3 : 2;
            expAck  = 2'b01;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  seqAck[8];
    logic [63:0] er;
    logic        ek;
    seqAck = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    xresetl = 1'b0;
    applyStimulus(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge sys_clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_ack", 64'(ack), 64'd0);
    checkOutput("reset_res", res, 64'd0);
    checkOutput("reset_co", 64'(co), 64'd0);
    waitCycle();
    xresetl = 1'b1;
    waitCycle();

    // 32-bit add with a carry out of the low word
    applyStimulus(0, 64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b0, 1'b1);
    waitCycle();
    checkOutput("t1_busy_lo", 64'(busy), 64'd1);
    checkOutput("t1_add_a", 64'(add_a), 64'hFFFF_FFFF);
    checkOutput("t1_ack_early", 64'(ack), 64'd0);
    waitCycle();
    checkOutput("t1_ack", 64'(ack), 64'b01);
    checkOutput("t1_res", res, 64'd0);
    checkOutput("t1_co", 64'(co), 64'd1);
    reqA[0] = 1'b0;
    waitCycle();
    checkOutput("t1_ack_pulse", 64'(ack), 64'd0);

    // Same operands as a 64-bit add: the carry ripples into the high word
    applyStimulus(0, 64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b1, 1'b1);
    waitCycle();
    waitCycle();
    checkOutput("t2_busy_hi", 64'(busy), 64'd1);
    checkOutput("t2_hi_ci", 64'(add_ci), 64'd1);
    checkOutput("t2_ack_early", 64'(ack), 64'd0);
    waitCycle();
    checkOutput("t2_ack", 64'(ack), 64'b01);
    checkOutput("t2_res", res, 64'h00000001_00000000);
    checkOutput("t2_co", 64'(co), 64'd0);
    reqA[0] = 1'b0;
    waitCycle();

    // Reset during the HI pass of a 64-bit op
    applyStimulus(0, 64'h00000005_00000003, 64'h00000001_00000004, 1'b0, 1'b1, 1'b1);
    waitCycle();
    waitCycle();
    checkOutput("t5_in_hi", 64'(busy), 64'd1);
    #2 xresetl = 1'b0;
    #1;
    checkOutput("t5_busy", 64'(busy), 64'd0);
    checkOutput("t5_ack", 64'(ack), 64'd0);
    checkOutput("t5_res", res, 64'd0);
    checkOutput("t5_co", 64'(co), 64'd0);

    // Both requesters pending after reset: grants alternate starting at requester 0
    applyStimulus(0, 64'h10, 64'h20, 1'b1, 1'b0, 1'b1);
    applyStimulus(1, 64'h12345678, 64'h11111111, 1'b0, 1'b0, 1'b1);
    #1 xresetl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      waitCycle();
      checkOutput("t3_ack_seq", 64'(ack), 64'(seqAck[i]));
      if (ack[0]) checkOutput("t3_res0", res, 64'h31);
      if (ack[1]) checkOutput("t3_res1", res, 64'h23456789);
    end
    reqA[0] = 1'b0;
    reqA[1] = 1'b0;
    waitCycle();
    waitCycle();

    // req0 held continuously: never re-granted in its own ack cycle
    applyStimulus(0, 64'd7, 64'd9, 1'b0, 1'b0, 1'b1);
    waitCycle();
    checkOutput("t4_busy1", 64'(busy), 64'd1);
    waitCycle();
    checkOutput("t4_ack1", 64'(ack), 64'b01);
    checkOutput("t4_res", res, 64'd16);
    checkOutput("t4_not_regranted", 64'(busy), 64'd0);
    waitCycle();
    checkOutput("t4_idle_busy", 64'(busy), 64'd0);
    checkOutput("t4_idle_ack", 64'(ack), 64'd0);
    waitCycle();
    checkOutput("t4_regrant", 64'(busy), 64'd1);
    waitCycle();
    checkOutput("t4_ack2", 64'(ack), 64'b01);
    reqA[0] = 1'b0;
    waitCycle();
    waitCycle();

    // Randomised traffic from both requesters
    monActive = 1'b1;
    fork
      agent(0);
      agent(1);
    join
    waitCycle();
    monActive = 1'b0;

    expectedResult(64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b1, er, ek);
    applyStimulus(1, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b1, 1'b1);
    repeat (3) waitCycle();
    checkOutput("wrap_ack", 64'(ack), 64'b10);
    checkOutput("wrap_res", res, er);
    checkOutput("wrap_co", 64'(co), 64'(ek));
    reqA[1] = 1'b0;
    waitCycle();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
